// File: rtl/audio_pkg.sv
// Shared types and limits for the codec audio path.
package audio_pkg;

    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_LJ  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } ser_state_e;

    localparam int SAMPLE_W_MIN = 8;
    localparam int SAMPLE_W_MAX = 32;

endpackage

// File: rtl/mod_sample_fifo.sv
// Single-clock FIFO of stereo sample pairs; read data is the head entry (show-ahead).
module mod_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                           i_aud_bclk,
    input  logic                           i_nrst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign o_full  = (count == LEVEL_W'(DEPTH));
    assign o_empty = (count == '0);
    assign o_level = count;
    assign o_rdata = mem[rd_ptr];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // NOTE: storage has no reset; only the pointers and count define validity,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge i_aud_bclk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_aud_bclk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LEVEL_W'(1);
                2'b01:   count <= count - LEVEL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mod_dac_serializer.sv
// Stereo DAC serializer: buffers sample pairs and shifts them MSB-first on DACDAT,
// framed by the codec-mastered BCLK/DACLRCK in I2S or left-justified format.
module mod_dac_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MODE       = 0
) (
    input  logic                                i_aud_bclk,
    input  logic                                i_nrst,
    input  logic                                i_aud_daclrck,
    input  logic [SAMPLE_W-1:0]                 i_sample_l,
    input  logic [SAMPLE_W-1:0]                 i_sample_r,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic                                i_mute,
    input  logic                                i_underrun_hold,
    output logic                                o_aud_dacdat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_level,
    output logic                                o_underrun,
    output logic                                o_frame_pulse
);

    localparam mode_e MODE_SEL = (MODE == 1) ? MODE_LJ : MODE_I2S;

    if (SAMPLE_W < SAMPLE_W_MIN || SAMPLE_W > SAMPLE_W_MAX) begin : g_bad_sample_w
        $error("mod_dac_serializer: SAMPLE_W out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mod_dac_serializer: FIFO_DEPTH must be a power of 2, at least 2");
    end

    ser_state_e            state_q;
    ser_state_e            state_d;
    logic                  lrck_q;
    logic                  lrck_fall;
    logic                  lrck_rise;
    logic                  frame_start;
    logic                  slot_r_start;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*SAMPLE_W-1:0] fifo_rdata;

    logic [SAMPLE_W-1:0]   hold_l;
    logic [SAMPLE_W-1:0]   hold_r;
    logic [SAMPLE_W-1:0]   tx_r;
    logic [SAMPLE_W-1:0]   frame_l;
    logic [SAMPLE_W-1:0]   frame_r;
    logic [SAMPLE_W-1:0]   slot_data;
    logic [SAMPLE_W-1:0]   shift_q;
    logic                  dacdat_q;
    logic                  underrun_q;
    logic                  frame_pulse_q;

    assign lrck_fall = lrck_q && !i_aud_daclrck;
    assign lrck_rise = !lrck_q && i_aud_daclrck;

    assign fifo_push = i_valid && !fifo_full;
    assign fifo_pop  = frame_start && !fifo_empty;

    mod_sample_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_aud_bclk (i_aud_bclk),
        .i_nrst     (i_nrst),
        .i_push     (fifo_push),
        .i_wdata    ({i_sample_l, i_sample_r}),
        .i_pop      (fifo_pop),
        .o_rdata    (fifo_rdata),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty),
        .o_level    (o_level)
    );

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        frame_start  = 1'b0;
        slot_r_start = 1'b0;
        case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
                if (lrck_fall) begin
                    state_d     = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                frame_start  = lrck_fall;
                slot_r_start = lrck_rise;
            end
            default: state_d = IDLE;
        endcase
    end

    // Samples for the frame about to start: fresh pair, replay, or silence.
    always_comb begin
        frame_l = '0;
        frame_r = '0;
        if (!fifo_empty) begin
            frame_l = fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
            frame_r = fifo_rdata[SAMPLE_W-1:0];
        end else if (i_underrun_hold) begin
            frame_l = hold_l;
            frame_r = hold_r;
        end
        if (i_mute) begin
            frame_l = '0;
            frame_r = '0;
        end
    end

    assign slot_data = frame_start ? frame_l : tx_r;

    always_ff @(posedge i_aud_bclk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q       <= IDLE;
            lrck_q        <= 1'b0;
            hold_l        <= '0;
            hold_r        <= '0;
            tx_r          <= '0;
            underrun_q    <= 1'b0;
            frame_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lrck_q        <= i_aud_daclrck;
            underrun_q    <= frame_start && fifo_empty;
            frame_pulse_q <= frame_start;
            if (fifo_pop) begin
                hold_l <= fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
                hold_r <= fifo_rdata[SAMPLE_W-1:0];
            end
            if (frame_start) begin
                tx_r <= frame_r;
            end
        end
    end

    // Each slot reloads from scratch, so a short slot simply drops the LSBs.
    always_ff @(posedge i_aud_bclk or negedge i_nrst) begin
        if (!i_nrst) begin
            shift_q  <= '0;
            dacdat_q <= 1'b0;
        end else if (frame_start || slot_r_start) begin
            if (MODE_SEL == MODE_LJ) begin
                dacdat_q <= slot_data[SAMPLE_W-1];
                shift_q  <= {slot_data[SAMPLE_W-2:0], 1'b0};
            end else begin
                dacdat_q <= 1'b0;
                shift_q  <= slot_data;
            end
        end else begin
            dacdat_q <= shift_q[SAMPLE_W-1];
            shift_q  <= {shift_q[SAMPLE_W-2:0], 1'b0};
        end
    end

    assign o_ready       = !fifo_full;
    assign o_aud_dacdat  = dacdat_q;
    assign o_underrun    = underrun_q;
    assign o_frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_mod_dac_serializer.sv
// Bench for mod_dac_serializer: I2S and left-justified instances share stimulus and
// are checked every cycle against a queue-based model plus literal expectations.
module tb_mod_dac_serializer;

    localparam int W       = 16;
    localparam int DEPTH   = 8;
    localparam int LEVEL_W = $clog2(DEPTH+1);

    logic               clk;
    logic               nrst;
    logic               lrck;
    logic [W-1:0]       sl;
    logic [W-1:0]       sr;
    logic               valid;
    logic               mute;
    logic               uhold;

    logic               rdy0, dac0, ur0, fp0;
    logic [LEVEL_W-1:0] lvl0;
    logic               rdy1, dac1, ur1, fp1;
    logic [LEVEL_W-1:0] lvl1;

    int n_checks;
    int n_fail;
    bit chk_en;
    bit rand_mode;
    int fp_cnt;
    int ur_cnt;

    mod_dac_serializer #(.SAMPLE_W(W), .FIFO_DEPTH(DEPTH), .MODE(0)) dut_i2s (
        .i_aud_bclk      (clk),
        .i_nrst          (nrst),
        .i_aud_daclrck   (lrck),
        .i_sample_l      (sl),
        .i_sample_r      (sr),
        .i_valid         (valid),
        .o_ready         (rdy0),
        .i_mute          (mute),
        .i_underrun_hold (uhold),
        .o_aud_dacdat    (dac0),
        .o_level         (lvl0),
        .o_underrun      (ur0),
        .o_frame_pulse   (fp0)
    );

    mod_dac_serializer #(.SAMPLE_W(W), .FIFO_DEPTH(DEPTH), .MODE(1)) dut_lj (
        .i_aud_bclk      (clk),
        .i_nrst          (nrst),
        .i_aud_daclrck   (lrck),
        .i_sample_l      (sl),
        .i_sample_r      (sr),
        .i_valid         (valid),
        .o_ready         (rdy1),
        .i_mute          (mute),
        .i_underrun_hold (uhold),
        .o_aud_dacdat    (dac1),
        .o_level         (lvl1),
        .o_underrun      (ur1),
        .o_frame_pulse   (fp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_phase;   // posedges since reset: 0 = first, 1 = waiting for fall, 2 = running
    logic         m_prev;
    logic [2*W-1:0] m_q[$];
    logic [W-1:0] m_hold_l, m_hold_r, m_frame_r, m_cur;
    int           m_pos;     // posedges since the current slot began
    bit           exp_frame, exp_under;

    // Bit expected on DACDAT 'pos' cycles after the slot-start edge.
    function automatic logic exp_bit(input logic [W-1:0] s, input int pos, input bit lj);
        int idx;
        idx = lj ? pos : pos - 1;
        if (idx < 0 || idx >= W) return 1'b0;
        return s[W-1-idx];
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_prev    = 1'b0;
        m_q.delete();
        m_hold_l  = '0;
        m_hold_r  = '0;
        m_frame_r = '0;
        m_cur     = '0;
        m_pos     = 0;
        exp_frame = 1'b0;
        exp_under = 1'b0;
    endtask

    task automatic model_step();
        bit             fall, rise, fs, rs, acc;
        logic [2*W-1:0] pair;
        logic [W-1:0]   fl, fr;
        fall = m_prev && !lrck;
        rise = !m_prev && lrck;
        fs = 1'b0;
        rs = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (fall) begin
                m_phase = 2;
                fs = 1'b1;
            end
        end else begin
            fs = fall;
            rs = rise;
        end
        acc       = valid && (m_q.size() < DEPTH);
        exp_frame = fs;
        exp_under = fs && (m_q.size() == 0);
        if (fs) begin
            fl = '0;
            fr = '0;
            if (m_q.size() > 0) begin
                pair     = m_q.pop_front();
                m_hold_l = pair[2*W-1:W];
                m_hold_r = pair[W-1:0];
                fl = m_hold_l;
                fr = m_hold_r;
            end else if (uhold) begin
                fl = m_hold_l;
                fr = m_hold_r;
            end
            if (mute) begin
                fl = '0;
                fr = '0;
            end
            m_cur     = fl;
            m_frame_r = fr;
            m_pos     = 0;
        end else if (rs) begin
            m_cur = m_frame_r;
            m_pos = 0;
        end else if (m_pos < 1000) begin
            m_pos++;
        end
        if (acc) m_q.push_back({sl, sr});
        m_prev = lrck;
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) model_reset();
        else       model_step();
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dacdat_i2s", 64'(dac0), 64'(exp_bit(m_cur, m_pos, 1'b0)));
            check("dacdat_lj",  64'(dac1), 64'(exp_bit(m_cur, m_pos, 1'b1)));
            check("level_i2s",  64'(lvl0), 64'(m_q.size()));
            check("level_lj",   64'(lvl1), 64'(m_q.size()));
            check("ready_i2s",  64'(rdy0), 64'(m_q.size() < DEPTH));
            check("ready_lj",   64'(rdy1), 64'(m_q.size() < DEPTH));
            check("underrun_i2s", 64'(ur0), 64'(exp_under));
            check("underrun_lj",  64'(ur1), 64'(exp_under));
            check("frame_i2s",  64'(fp0), 64'(exp_frame));
            check("frame_lj",   64'(fp1), 64'(exp_frame));
        end
        if (nrst) begin
            fp_cnt += int'(fp1);
            ur_cnt += int'(ur1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        valid = 1'b1;
        sl    = l;
        sr    = r;
        tick();
        valid = 1'b0;
    endtask

    // Drives one LRCK slot of 'len' BCLKs; bit j of the capture is DACDAT after posedge k+j.
    task automatic run_slot(input logic lr, input int len, output logic [63:0] cap0, output logic [63:0] cap1);
        cap0 = '0;
        cap1 = '0;
        lrck = lr;
        for (int j = 0; j < len; j++) begin
            tick();
            if (j < 64) begin
                cap0[63-j] = dac0;
                cap1[63-j] = dac1;
            end
            if (rand_mode) begin
                valid = ($urandom_range(0, 29) == 0);
                sl    = W'($urandom);
                sr    = W'($urandom);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dacdat"}, 64'({dac0, dac1}), 64'(2'b00));
        check({tag, "_ready"},  64'({rdy0, rdy1}), 64'(2'b11));
        check({tag, "_level"},  64'({lvl0, lvl1}), 64'(0));
        check({tag, "_underrun"}, 64'({ur0, ur1}), 64'(2'b00));
        check({tag, "_frame"},  64'({fp0, fp1}), 64'(2'b00));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] c0, c1;
        int fp0_s, ur0_s;

        n_checks  = 0;
        n_fail    = 0;
        rand_mode = 1'b0;
        fp_cnt    = 0;
        ur_cnt    = 0;
        nrst  = 1'b0;
        lrck  = 1'b0;
        sl    = '0;
        sr    = '0;
        valid = 1'b0;
        mute  = 1'b0;
        uhold = 1'b0;
        model_reset();
        chk_en = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 nrst = 1'b1;
        tick();

        // Basic frame, both framings.
        push_pair(16'hA5C3, 16'h0F0F);
        check("level_after_push", 64'(lvl1), 64'(1));
        fp0_s = fp_cnt;
        run_slot(1'b1, 8, c0, c1);
        run_slot(1'b0, 32, c0, c1);
        check("left_i2s_bits", c0[63:32], 64'(32'h52E1_8000));
        check("left_lj_bits",  c1[63:32], 64'(32'hA5C3_0000));
        check("level_after_frame", 64'(lvl1), 64'(0));
        run_slot(1'b1, 32, c0, c1);
        check("right_i2s_bits", c0[63:32], 64'(32'h0787_8000));
        check("right_lj_bits",  c1[63:32], 64'(32'h0F0F_0000));
        check("frame_pulses_one", 64'(fp_cnt - fp0_s), 64'(1));

        // Fill past full with LRCK held.
        valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sl = W'(16'h1000 + i);
            sr = W'(16'h2000 + i);
            tick();
        end
        valid = 1'b0;
        check("full_level", 64'(lvl0), 64'(8));
        check("full_ready", 64'({rdy0, rdy1}), 64'(2'b00));
        run_slot(1'b0, 20, c0, c1);
        check("pop_level", 64'(lvl1), 64'(7));
        check("pop_ready", 64'({rdy0, rdy1}), 64'(2'b11));
        check("pop_left_data", c1[63:48], 64'(16'h1000));
        run_slot(1'b1, 20, c0, c1);
        check("pop_right_data", c1[63:48], 64'(16'h2000));

        // Reset in the middle of a left slot with four pairs still queued.
        for (int f = 0; f < 2; f++) begin
            run_slot(1'b0, 20, c0, c1);
            run_slot(1'b1, 20, c0, c1);
        end
        lrck = 1'b0;
        repeat (6) tick();
        check("pre_reset_level", 64'(lvl1), 64'(4));
        #2 nrst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) tick();
        #2 nrst = 1'b1;
        tick();

        // Nothing may move until a falling edge is seen after IDLE and SYNC.
        fp0_s = fp_cnt;
        for (int i = 0; i < 3; i++) push_pair(W'(16'h7F00 + i), W'(16'h8100 + i));
        run_slot(1'b1, 10, c0, c1);
        check("sync_no_pop", 64'(lvl1), 64'(3));
        check("sync_no_frame", 64'(fp_cnt - fp0_s), 64'(0));
        check("sync_quiet", {c0[63:54], c1[63:54]}, 64'(0));

        // Mute drains the queue while sending silence.
        mute  = 1'b1;
        ur0_s = ur_cnt;
        for (int f = 0; f < 3; f++) begin
            run_slot(1'b0, 20, c0, c1);
            check("mute_left_zero", {c0[63:44], c1[63:44]}, 64'(0));
            run_slot(1'b1, 20, c0, c1);
            check("mute_right_zero", {c0[63:44], c1[63:44]}, 64'(0));
        end
        mute = 1'b0;
        check("mute_level", 64'(lvl1), 64'(0));
        check("mute_no_underrun", 64'(ur_cnt - ur0_s), 64'(0));
        check("mute_frames", 64'(fp_cnt - fp0_s), 64'(3));

        // Underrun: replay versus zeros.
        push_pair(16'h1234, 16'h8000);
        run_slot(1'b0, 20, c0, c1);
        check("last_left", c1[63:48], 64'(16'h1234));
        run_slot(1'b1, 20, c0, c1);
        uhold = 1'b1;
        ur0_s = ur_cnt;
        run_slot(1'b0, 20, c0, c1);
        check("hold_left_lj",  c1[63:48], 64'(16'h1234));
        check("hold_left_i2s", c0[62:47], 64'(16'h1234));
        check("hold_underrun", 64'(ur_cnt - ur0_s), 64'(1));
        run_slot(1'b1, 20, c0, c1);
        check("hold_right_lj", c1[63:48], 64'(16'h8000));
        uhold = 1'b0;
        run_slot(1'b0, 20, c0, c1);
        check("zero_left", {c0[63:44], c1[63:44]}, 64'(0));
        check("zero_underrun", 64'(ur_cnt - ur0_s), 64'(2));
        run_slot(1'b1, 20, c0, c1);
        check("zero_right", {c0[63:44], c1[63:44]}, 64'(0));

        // Randomised traffic with varied slot lengths, including truncating slots.
        rand_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            mute  = ($urandom_range(0, 7) == 0);
            uhold = 1'($urandom_range(0, 1));
            run_slot(1'b0, $urandom_range(2, 40), c0, c1);
            run_slot(1'b1, $urandom_range(2, 40), c0, c1);
            if (f == 30) begin
                #2 nrst = 1'b0;
                tick();
                tick();
                #2 nrst = 1'b1;
                tick();
            end
        end
        rand_mode = 1'b0;
        valid = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_dac_serializer.md
# mod_dac_serializer

Parametrised stereo DAC serializer for the WM8731 path. It buffers stereo sample pairs from the synthesizer in a small FIFO and shifts them out MSB-first on DACDAT, in either I2S or left-justified framing, locked to the codec-mastered BCLK/DACLRCK. It adds configurable sample width, FIFO depth, framing mode, mute, and defined underrun behaviour with status outputs. It sits between `mod_synth` and the codec pins.

## Interface
- `SAMPLE_W`, default 16: bits per channel sample, legal range 8..32.
- `FIFO_DEPTH`, default 8: number of stereo pairs buffered; power of 2, at least 2.
- `MODE`, default 0: 0 = I2S (MSB delayed one BCLK), 1 = left-justified.
- `i_aud_bclk`, in, 1: codec bit clock; all logic on posedge.
- `i_nrst`, in, 1: reset, asynchronous, active-low.
- `i_aud_daclrck`, in, 1: codec LR clock. Low = left slot, high = right slot.
- `i_sample_l`, in, `SAMPLE_W`: left sample, two's complement.
- `i_sample_r`, in, `SAMPLE_W`: right sample, two's complement.
- `i_valid`, in, 1: sample pair offered.
- `o_ready`, out, 1: FIFO can accept a pair.
- `i_mute`, in, 1: force zero output, sampled at frame start.
- `i_underrun_hold`, in, 1: on underrun, 1 = replay the last pair, 0 = send zeros.
- `o_aud_dacdat`, out, 1: serial data to the codec.
- `o_level`, out, `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.
- `o_underrun`, out, 1: one-cycle pulse when a frame starts with the FIFO empty.
- `o_frame_pulse`, out, 1: one-cycle pulse at each frame start.

## Operation
- **LRCK tracking.** `lrck_q` holds LRCK as registered each posedge. An edge is detected when `i_aud_daclrck != lrck_q`.
  - Falling edge: frame start (left slot).
  - Rising edge: right slot start.
- **FSM `IDLE -> SYNC -> RUN`.**
  - IDLE: first posedge after reset captures `lrck_q` only, then moves to SYNC. No edge is acted on.
  - SYNC: waits for a falling edge; on it, moves to RUN and performs a frame start.
  - RUN: remains in RUN until reset.
- **Frame start.**
  - Pops one pair if the FIFO is non-empty; the popped pair goes into `hold_l`/`hold_r`.
  - If the FIFO is empty: `o_underrun` pulses, and the frame sends `hold_*` when `i_underrun_hold`=1, else zeros.
  - `i_mute`=1 zeros the transmitted frame but still pops, so data flow continues.
  - `o_frame_pulse` pulses.
- **Slot start.** Loads the shift register with the channel sample: left at a falling edge, right at a rising edge.
- **Shifting.** Sends `SAMPLE_W` bits MSB-first, then 0 until the next LRCK edge.
  - A slot shorter than the sample truncates the LSBs.
  - Bits do not carry across slots.
- **FIFO writes.** Write happens when `i_valid && o_ready`. `o_ready` = !full.
  - No bypass: a push and a pop in the same cycle on an empty FIFO is an underrun, and the pushed pair is kept.
  - Simultaneous push and pop when neither full nor empty leaves `o_level` unchanged.
- **Mid-operation reset.** Flushes the FIFO and returns the FSM to IDLE; `hold_*` clears to 0.

## Timing
- Reset values:
  - `o_aud_dacdat`=0, `o_ready`=1, `o_level`=0, `o_underrun`=0, `o_frame_pulse`=0.
  - `lrck_q`=0, `hold_l`/`hold_r`=0, FSM=IDLE.
- Edge-detect posedge is called k.
  - MODE=1: MSB is on `o_aud_dacdat` from posedge k; bit i is driven from posedge k+(`SAMPLE_W`-1-i).
  - MODE=0: everything is shifted one cycle later, so MSB is driven from posedge k+1.
- `o_frame_pulse`, `o_underrun`, and the pop (`o_level` decrement) are all registered, visible after posedge k.
- Push-to-level latency: 1 cycle. `o_ready` falls in the cycle after the push that fills the FIFO.
- Minimum slot length: 2 BCLK for MODE=0, 1 for MODE=1. Shorter LRCK pulses are unsupported.

## Structure
- `audio_pkg`: `mode_e` (`MODE_I2S`, `MODE_LJ`), `ser_state_e` (`IDLE`, `SYNC`, `RUN`), and the legal `SAMPLE_W` range constants.
- Sub-module `mod_sample_fifo`: single-clock FIFO with parameters `WIDTH`=2*`SAMPLE_W` and `DEPTH`; ports for push, pop, full, empty, and level.
- Top: LRCK edge detect, FSM, hold registers, shift register.

## Test plan
- SAMPLE_W=16, MODE=0, 32-BCLK slots, push L=16'hA5C3, R=16'h0F0F before the first falling edge:
  - Left slot: bits 1010010111000011 starting at k+1, then 16 zeros.
  - Right slot: 0000111100001111.
  - `o_frame_pulse` is 1 once; `o_level` goes 1->0.
- Same stimulus with MODE=1: identical bit sequences, each starting at posedge k.
- FIFO_DEPTH=8 with no LRCK edges, 9 consecutive valid pushes:
  - First 8 accepted, `o_level`=8, `o_ready`=0; 9th not accepted.
  - After one frame start: `o_level`=7, `o_ready`=1.
- Empty FIFO at a frame start, last pair 16'h1234/16'h8000:
  - `i_underrun_hold`=1: `o_underrun` pulses and 1234/8000 is retransmitted.
  - `i_underrun_hold`=0: all-zero frame.
- `i_mute`=1 with 3 pairs queued: 3 frames of zeros, `o_level` goes 3->0, no `o_underrun`.
- Assert `i_nrst` mid left slot with 4 pairs queued:
  - Outputs return to reset values immediately.
  - After release: no output activity and no pop until the FSM has passed IDLE and SYNC and seen a falling LRCK edge.
